// File: rtl/jump_control_unit.sv
// jump_control_unit: Moore control sequencer for Mini SRC fetch and br/jr/jal/addi/nop/halt.
// Define CU_STEP_EN to add the step input and an idle wait state before each fetch.
module jump_control_unit #(
   parameter logic [4:0] ADD_OP   = 5'b00011,
   parameter logic [3:0] LINK_REG = 4'd15
) (
   input  logic        clk,
   input  logic        clr,
`ifdef CU_STEP_EN
   input  logic        step,
`endif
   input  logic [31:0] IR,
   input  logic        CON_output,
   output logic        PC_out,
   output logic        MDR_out,
   output logic        Zlo_out,
   output logic        R_out,
   output logic        C_out,
   output logic        MAR_rd,
   output logic        PC_rd,
   output logic        MDR_rd,
   output logic        IR_rd,
   output logic        Y_rd,
   output logic        Zlo_rd,
   output logic        Rin,
   output logic        CONin,
   output logic        Gra,
   output logic        Grb,
   output logic        Grc,
   output logic        BAout,
   output logic        IncPC,
   output logic        Read,
   output logic        Write,
   output logic        link_sel,
   output logic [4:0]  op_sel,
   output logic        Run
);

   typedef enum logic [4:0] {
      S_RST, S_IDLE, S_T0, S_T1, S_T2,
      S_BR3, S_BR4, S_BR5, S_BR6,
      S_JR3, S_JAL3, S_JAL4,
      S_ADDI3, S_ADDI4, S_ADDI5,
      S_HALT
   } state_t;

   state_t state_q, state_d, fetch_d;
   logic   unused_ok;

   // link register index is applied by the datapath when link_sel is high
   assign unused_ok = ^{IR[26:0], LINK_REG};

`ifdef CU_STEP_EN
   assign fetch_d = step ? S_T0 : S_IDLE;
`else
   assign fetch_d = S_T0;
`endif

   always_ff @(posedge clk) begin
      if (clr) state_q <= S_RST;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_RST:   state_d = fetch_d;
         S_IDLE:  state_d = fetch_d;
         S_T0:    state_d = S_T1;
         S_T1:    state_d = S_T2;
         S_T2: begin
            unique case (IR[31:27])
               5'b10011: state_d = S_BR3;
               5'b10100: state_d = S_JR3;
               5'b10101: state_d = S_JAL3;
               5'b01100: state_d = S_ADDI3;
               5'b11011: state_d = S_HALT;
               default:  state_d = fetch_d;
            endcase
         end
         S_BR3:   state_d = S_BR4;
         S_BR4:   state_d = S_BR5;
         S_BR5:   state_d = S_BR6;
         S_BR6:   state_d = fetch_d;
         S_JR3:   state_d = fetch_d;
         S_JAL3:  state_d = S_JAL4;
         S_JAL4:  state_d = fetch_d;
         S_ADDI3: state_d = S_ADDI4;
         S_ADDI4: state_d = S_ADDI5;
         S_ADDI5: state_d = fetch_d;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_RST;
      endcase
   end

   always_comb begin
      PC_out   = 1'b0;
      MDR_out  = 1'b0;
      Zlo_out  = 1'b0;
      R_out    = 1'b0;
      C_out    = 1'b0;
      MAR_rd   = 1'b0;
      PC_rd    = 1'b0;
      MDR_rd   = 1'b0;
      IR_rd    = 1'b0;
      Y_rd     = 1'b0;
      Zlo_rd   = 1'b0;
      Rin      = 1'b0;
      CONin    = 1'b0;
      Gra      = 1'b0;
      Grb      = 1'b0;
      Grc      = 1'b0;
      BAout    = 1'b0;
      IncPC    = 1'b0;
      Read     = 1'b0;
      Write    = 1'b0;
      link_sel = 1'b0;
      op_sel   = 5'd0;
      Run      = 1'b1;
      unique case (state_q)
         S_T0: begin
            PC_out = 1'b1; MAR_rd = 1'b1;
            IncPC  = 1'b1; Zlo_rd = 1'b1;
         end
         S_T1: begin
            Zlo_out = 1'b1; PC_rd  = 1'b1;
            Read    = 1'b1; MDR_rd = 1'b1;
         end
         S_T2: begin
            MDR_out = 1'b1; IR_rd = 1'b1;
         end
         S_JR3, S_JAL4: begin
            Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1;
         end
         S_JAL3: begin
            PC_out = 1'b1; Rin = 1'b1; link_sel = 1'b1;
         end
         S_BR3: begin
            Gra = 1'b1; R_out = 1'b1; CONin = 1'b1;
         end
         S_BR4: begin
            PC_out = 1'b1; Y_rd = 1'b1;
         end
         S_BR5, S_ADDI4: begin
            C_out = 1'b1; op_sel = ADD_OP; Zlo_rd = 1'b1;
         end
         // the branch commit is the one input-dependent strobe
         S_BR6: begin
            Zlo_out = 1'b1; PC_rd = CON_output;
         end
         S_ADDI3: begin
            Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1;
         end
         S_ADDI5: begin
            Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1;
         end
         S_HALT:  Run = 1'b0;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_jump_control_unit.sv
// tb_jump_control_unit: directed strobe sequences plus a small behavioural datapath.
// Covers fetch, jr, jal, br taken/not, addi, halt, mid-instruction clr and step mode.
module tb_jump_control_unit;

   logic clk = 1'b0;
   logic clr, CON_output, step;
   logic [31:0] IR;
   logic PC_out, MDR_out, Zlo_out, R_out, C_out;
   logic MAR_rd, PC_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Rin, CONin;
   logic Gra, Grb, Grc, BAout, IncPC, Read, Write, link_sel, Run;
   logic [4:0] op_sel;
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   jump_control_unit dut (
      .clk(clk), .clr(clr),
`ifdef CU_STEP_EN
      .step(step),
`endif
      .IR(IR), .CON_output(CON_output),
      .PC_out(PC_out), .MDR_out(MDR_out), .Zlo_out(Zlo_out),
      .R_out(R_out), .C_out(C_out), .MAR_rd(MAR_rd), .PC_rd(PC_rd),
      .MDR_rd(MDR_rd), .IR_rd(IR_rd), .Y_rd(Y_rd), .Zlo_rd(Zlo_rd),
      .Rin(Rin), .CONin(CONin), .Gra(Gra), .Grb(Grb), .Grc(Grc),
      .BAout(BAout), .IncPC(IncPC), .Read(Read), .Write(Write),
      .link_sel(link_sel), .op_sel(op_sel), .Run(Run)
   );

   localparam logic [19:0] PCO = 20'h80000, MDRO = 20'h40000;
   localparam logic [19:0] ZLO = 20'h20000, RO = 20'h10000;
   localparam logic [19:0] CO = 20'h08000, MARI = 20'h04000;
   localparam logic [19:0] PCI = 20'h02000, MDRI = 20'h01000;
   localparam logic [19:0] IRI = 20'h00800, YI = 20'h00400;
   localparam logic [19:0] ZLI = 20'h00200, RIN = 20'h00100;
   localparam logic [19:0] CONI = 20'h00080, GRA = 20'h00040;
   localparam logic [19:0] INC = 20'h00008, RD = 20'h00004;
   localparam logic [19:0] LNK = 20'h00001;
   localparam logic [4:0]  ADD = 5'b00011;

   logic [19:0] sv;
   assign sv = {PC_out, MDR_out, Zlo_out, R_out, C_out, MAR_rd, PC_rd,
                MDR_rd, IR_rd, Y_rd, Zlo_rd, Rin, CONin, Gra, Grb,
                BAout, IncPC, Read, Write, link_sel};

   // behavioural datapath: bus, PC, Y, Z and a register file
   logic [31:0] pc_m, y_m, z_m, bus, c_sx;
   logic [31:0] rf [16];
   logic [3:0]  ra, rb;
   assign ra   = IR[26:23];
   assign rb   = IR[22:19];
   assign c_sx = {{13{IR[18]}}, IR[18:0]};
   always_comb begin
      bus = 32'd0;
      if (PC_out)       bus = pc_m;
      else if (Zlo_out) bus = z_m;
      else if (R_out)   bus = rf[Gra ? ra : rb];
      else if (C_out)   bus = c_sx;
   end
   always @(posedge clk) begin
      if (clr) begin
         pc_m <= 32'd0; y_m <= 32'd0; z_m <= 32'd0;
         rf[8] <= 32'h20; rf[5] <= 32'h40;
         rf[3] <= 32'd10; rf[2] <= 32'd0; rf[15] <= 32'd0;
      end else begin
         if (Zlo_rd)
            z_m <= IncPC ? bus + 1 : (op_sel == ADD ? y_m + bus : bus);
         if (PC_rd) pc_m <= bus;
         if (Y_rd)  y_m <= bus;
         if (Rin)   rf[link_sel ? 4'd15 : (Gra ? ra : rb)] <= bus;
      end
   end

   always @(negedge clk) begin
      if (!clr) begin
         checks++;
         assert ($onehot0({PC_out, MDR_out, Zlo_out, R_out, C_out}))
         else begin
            errors++;
            $error("FAIL busx drivers=%b required at most one",
                   {PC_out, MDR_out, Zlo_out, R_out, C_out});
         end
      end
   end

   task automatic chk(input string tag, input logic run,
                      input logic [4:0] op, input logic [19:0] s);
      logic [25:0] obs, exp;
      obs = {op_sel, Run, sv};
      exp = {op, run, s};
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s got=%h required=%h", tag, obs, exp);
      end
   endtask

   task automatic st(input string tag, input logic run,
                     input logic [4:0] op, input logic [19:0] s);
      chk(tag, run, op, s);
      @(negedge clk);
   endtask

   task automatic chkv(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s got=%h required=%h", tag, obs, exp);
      end
   endtask

   task automatic fetch(input string tag);
      st({tag, "_t0"}, 1'b1, 5'd0, PCO | MARI | INC | ZLI);
      st({tag, "_t1"}, 1'b1, 5'd0, ZLO | PCI | RD | MDRI);
      st({tag, "_t2"}, 1'b1, 5'd0, MDRO | IRI);
   endtask

   initial begin
      clr = 1'b1; IR = 32'd0; CON_output = 1'b0; step = 1'b1;
      @(negedge clk); @(negedge clk);
      clr = 1'b0;
      st("rst", 1'b1, 5'd0, 20'd0);

      IR = 32'hA4000000;
      fetch("jr");
      st("jr3", 1'b1, 5'd0, GRA | RO | PCI);
      chkv("jr_pc", pc_m, 32'h20);

      IR = 32'hAA800000;
      fetch("jal");
      st("jal3", 1'b1, 5'd0, PCO | RIN | LNK);
      chkv("jal_r15", rf[15], 32'h21);
      st("jal4", 1'b1, 5'd0, GRA | RO | PCI);
      chkv("jal_pc", pc_m, 32'h40);

      IR = 32'h99000005; CON_output = 1'b1;
      fetch("brt");
      st("brt3", 1'b1, 5'd0, GRA | RO | CONI);
      st("brt4", 1'b1, 5'd0, PCO | YI);
      st("brt5", 1'b1, ADD, CO | ZLI);
      st("brt6", 1'b1, 5'd0, ZLO | PCI);
      chkv("brt_pc", pc_m, 32'h46);

      CON_output = 1'b0;
      fetch("brn");
      st("brn3", 1'b1, 5'd0, GRA | RO | CONI);
      st("brn4", 1'b1, 5'd0, PCO | YI);
      st("brn5", 1'b1, ADD, CO | ZLI);
      st("brn6", 1'b1, 5'd0, ZLO);
      chkv("brn_pc", pc_m, 32'h47);

      IR = 32'h61180007;
      fetch("addi");
      st("addi3", 1'b1, 5'd0, RO | 20'h00020 | YI);
      st("addi4", 1'b1, ADD, CO | ZLI);
      st("addi5", 1'b1, 5'd0, ZLO | GRA | RIN);
      chkv("addi_r2", rf[2], 32'd17);

      IR = 32'hD0000000;
      fetch("nop");
      IR = 32'h99000005;
      fetch("brc");
      st("brc3", 1'b1, 5'd0, GRA | RO | CONI);
      st("brc4", 1'b1, 5'd0, PCO | YI);
      chk("brc5", 1'b1, ADD, CO | ZLI);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      IR = 32'hD8000000;
      st("clr_rst", 1'b1, 5'd0, 20'd0);

      fetch("halt");
      for (int i = 0; i < 20; i++) st("halt", 1'b0, 5'd0, 20'd0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
`ifdef CU_STEP_EN
      step = 1'b0;
      IR = 32'hD0000000;
      for (int i = 0; i < 11; i++) st("idle", 1'b1, 5'd0, 20'd0);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      st("stp_t0", 1'b1, 5'd0, PCO | MARI | INC | ZLI);
      st("stp_t1", 1'b1, 5'd0, ZLO | PCI | RD | MDRI);
      st("stp_t2", 1'b1, 5'd0, MDRO | IRI);
      for (int i = 0; i < 3; i++) st("stp_idle", 1'b1, 5'd0, 20'd0);
`else
      st("halt_rst", 1'b1, 5'd0, 20'd0);
      st("post_t0", 1'b1, 5'd0, PCO | MARI | INC | ZLI);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
